// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device (inhibit, request-to-send, 11-bit frame, ACK check).
// Latency: INHIBIT_CYCLES + 1 cycles to request-to-send, then paced by the device clock, then a bus-idle wait.
// Backpressure: start is taken only while busy=0; a start seen during a transfer is dropped, never queued.

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       busy,
   output logic       tx_done_tick,
   output logic       err
);

   // One down-counter serves both the inhibit interval and the no-activity timeout,
   // so it is sized for whichever load value is larger.
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LD = CW'(INHIBIT_CYCLES);
   localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   // Pin conditioning
   logic       c_meta_q, c_sync_q;
   logic       d_meta_q, d_sync_q;
   logic [7:0] filt_sh_q;
   logic       filt_q, filt_d;
   logic       fall_tick;

   // Transfer state
   state_t          state_q;
   logic [8:0]      sh_q;
   logic [3:0]      n_q;
   logic [CW-1:0]   cnt_q;
   logic            to_active;
   logic            to_expired;

   // Two-flop synchronizers on both pins; an idle PS/2 bus sits high.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         c_meta_q <= 1'b1;
         c_sync_q <= 1'b1;
         d_meta_q <= 1'b1;
         d_sync_q <= 1'b1;
      end else begin
         c_meta_q <= ps2c_in;
         c_sync_q <= c_meta_q;
         d_meta_q <= ps2d_in;
         d_sync_q <= d_meta_q;
      end
   end

   // Filtered clock level moves only after eight identical synchronized samples.
   always_comb begin
      filt_d = filt_q;
      if (filt_sh_q == 8'h00) begin
         filt_d = 1'b0;
      end else if (filt_sh_q == 8'hFF) begin
         filt_d = 1'b1;
      end
   end

   // Clock sample history and filtered level.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         filt_sh_q <= 8'hFF;
         filt_q    <= 1'b1;
      end else begin
         filt_sh_q <= {filt_sh_q[6:0], c_sync_q};
         filt_q    <= filt_d;
      end
   end

   // A falling edge of the filtered clock is seen in the cycle before filt_q drops.
   assign fall_tick = filt_q & ~filt_d;

   // The device-paced phases share one watchdog; it only counts there.
   assign to_active  = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
   assign to_expired = to_active && (cnt_q == '0);

   // Transfer sequencer. ps2d_oe is itself the inverted current-bit register while shifting:
   // it is loaded with the start bit on SHIFT entry and with ~sh_q[0] on every fall.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         sh_q         <= '0;
         n_q          <= '0;
         cnt_q        <= '0;
         ps2c_oe      <= 1'b0;
         ps2d_oe      <= 1'b0;
         busy         <= 1'b0;
         tx_done_tick <= 1'b0;
         err          <= 1'b0;
      end else begin
         tx_done_tick <= 1'b0;
         if (to_expired) begin
            // Device stopped clocking: release both lines and report failure.
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            err          <= 1'b1;
            tx_done_tick <= 1'b1;
            busy         <= 1'b0;
            state_q      <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     // Parity bit makes the nine bits odd.
                     sh_q    <= {~^din, din};
                     err     <= 1'b0;
                     cnt_q   <= INH_LD;
                     busy    <= 1'b1;
                     ps2c_oe <= 1'b1;
                     ps2d_oe <= 1'b0;
                     state_q <= S_INHIBIT;
                  end
               end

               S_INHIBIT: begin
                  // Hold the clock low; counter was loaded on entry so this lasts INHIBIT_CYCLES.
                  if (cnt_q <= CNT_ONE) begin
                     ps2d_oe <= 1'b1;
                     state_q <= S_RTS;
                  end else begin
                     cnt_q <= cnt_q - CNT_ONE;
                  end
               end

               S_RTS: begin
                  // Data already low (start bit); release the clock so the device starts clocking.
                  n_q     <= '0;
                  cnt_q   <= TO_LD;
                  ps2c_oe <= 1'b0;
                  ps2d_oe <= 1'b1;
                  state_q <= S_SHIFT;
               end

               S_SHIFT: begin
                  if (fall_tick) begin
                     // The stop bit arrives as the 1 shifted in behind the parity bit.
                     ps2d_oe <= ~sh_q[0];
                     sh_q    <= {1'b1, sh_q[8:1]};
                     n_q     <= n_q + 4'd1;
                     cnt_q   <= TO_LD;
                     if (n_q == 4'd9) begin
                        state_q <= S_ACK;
                     end
                  end else begin
                     cnt_q <= cnt_q - CNT_ONE;
                  end
               end

               S_ACK: begin
                  // Device pulls data low for ACK; high means it rejected the frame.
                  if (fall_tick) begin
                     err     <= d_sync_q;
                     cnt_q   <= TO_LD;
                     state_q <= S_WAIT_IDLE;
                  end else begin
                     cnt_q <= cnt_q - CNT_ONE;
                  end
               end

               S_WAIT_IDLE: begin
                  // Finish only once the device has released both lines.
                  if (filt_q && d_sync_q) begin
                     tx_done_tick <= 1'b1;
                     busy         <= 1'b0;
                     state_q      <= S_IDLE;
                  end else if (fall_tick) begin
                     cnt_q <= TO_LD;
                  end else begin
                     cnt_q <= cnt_q - CNT_ONE;
                  end
               end

               default: begin
                  ps2c_oe <= 1'b0;
                  ps2d_oe <= 1'b0;
                  busy    <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain keyboard model.
// Latency: shortened inhibit/timeout parameters keep each transfer to a few hundred cycles.
// Backpressure: exercises dropped starts while busy, NACK, timeout and mid-transfer reset.

module tb_ps2_host_tx;

   localparam int INH  = 50;
   localparam int TO   = 300;
   localparam int HALF = 20;

   logic       CLK = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] din;
   logic       ps2c_in, ps2d_in;
   logic       ps2c_oe, ps2d_oe, busy, tx_done_tick, err;
   logic       kb_c_low, kb_d_low;

   int         total = 0;
   int         bad = 0;
   int         done_cnt = 0;
   int         cyc;
   int         d0;
   logic [9:0] rec;
   logic       blow;

   // Wired-AND open-drain bus with pull-ups.
   assign ps2c_in = ~(ps2c_oe | kb_c_low);
   assign ps2d_in = ~(ps2d_oe | kb_d_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .start       (start),
      .din         (din),
      .ps2c_in     (ps2c_in),
      .ps2d_in     (ps2d_in),
      .ps2c_oe     (ps2c_oe),
      .ps2d_oe     (ps2d_oe),
      .busy        (busy),
      .tx_done_tick(tx_done_tick),
      .err         (err)
   );

   always #5 CLK = ~CLK;

   // Count every done pulse, sampled away from the active edge.
   always @(negedge CLK) begin
      if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start and follow the inhibit / request-to-send sequence into SHIFT.
   task automatic begin_xfer(input logic [7:0] b, input string nm);
      int n;
      din   = b;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      din   = ~b;
      chk({nm, "_busy_on"}, busy, 1);
      chk({nm, "_err_clr"}, err, 0);
      n = 0;
      while (ps2c_oe === 1'b1 && ps2d_oe === 1'b0 && n < INH + 20) begin
         n++;
         @(negedge CLK);
      end
      chk({nm, "_inhibit_len"}, n, INH);
      chk({nm, "_rts"}, {ps2c_oe, ps2d_oe}, 2'b11);
      @(negedge CLK);
      chk({nm, "_shift_entry"}, {ps2c_oe, ps2d_oe}, 2'b01);
   endtask

   // Keyboard: nfalls clock pulses; records ps2d_oe just before each rising edge.
   task automatic kb_send(input int nfalls, input logic nack,
                          output logic [9:0] r, output logic busy_low);
      r = '0;
      busy_low = 1'b0;
      for (int i = 1; i <= nfalls; i++) begin
         if (i == 11 && !nack) kb_d_low = 1'b1;
         repeat (HALF) begin
            @(negedge CLK);
            if (busy !== 1'b1) busy_low = 1'b1;
         end
         kb_c_low = 1'b1;
         repeat (HALF) begin
            @(negedge CLK);
            if (busy !== 1'b1) busy_low = 1'b1;
         end
         if (i <= 10) r[i-1] = ps2d_oe;
         kb_c_low = 1'b0;
      end
      repeat (2) @(negedge CLK);
      kb_d_low = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int c);
      c = 0;
      while (tx_done_tick !== 1'b1 && c < limit) begin
         @(negedge CLK);
         c++;
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      din      = 8'h00;
      kb_c_low = 1'b0;
      kb_d_low = 1'b0;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_c_oe", ps2c_oe, 0);
      chk("rst_d_oe", ps2d_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", tx_done_tick, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;
      repeat (20) @(negedge CLK);
      chk("idle_oe", {ps2c_oe, ps2d_oe}, 2'b00);

      // 0xED with ACK: oe per fall = ~{stop, parity, d7..d0}
      begin_xfer(8'hED, "ed");
      d0 = done_cnt;
      kb_send(11, 1'b0, rec, blow);
      chk("ed_bits", rec, 10'h012);
      chk("ed_busy_held", blow, 0);
      wait_done(100, cyc);
      chk("ed_done", tx_done_tick, 1);
      chk("ed_err", err, 0);
      chk("ed_busy_fall", busy, 0);
      chk("ed_oe_rel", {ps2c_oe, ps2d_oe}, 2'b00);
      repeat (5) @(negedge CLK);
      chk("ed_one_done", done_cnt - d0, 1);

      // 0xF4: parity 0, plus a start pulse during SHIFT that must be dropped
      begin_xfer(8'hF4, "f4");
      d0 = done_cnt;
      din   = 8'h00;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      kb_send(11, 1'b0, rec, blow);
      chk("f4_bits", rec, 10'h10B);
      wait_done(100, cyc);
      chk("f4_done", tx_done_tick, 1);
      chk("f4_err", err, 0);
      repeat (100) @(negedge CLK);
      chk("f4_one_done", done_cnt - d0, 1);
      chk("f4_no_queue", {busy, ps2c_oe}, 2'b00);

      // 0x00: all data bits driven low, parity 1
      begin_xfer(8'h00, "z");
      kb_send(11, 1'b0, rec, blow);
      chk("z_bits", rec, 10'h0FF);
      wait_done(100, cyc);
      chk("z_done", tx_done_tick, 1);
      chk("z_err", err, 0);
      repeat (5) @(negedge CLK);

      // 0xAA rejected by the device
      begin_xfer(8'hAA, "nk");
      kb_send(11, 1'b1, rec, blow);
      chk("nk_bits", rec, 10'h055);
      wait_done(100, cyc);
      chk("nk_done", tx_done_tick, 1);
      chk("nk_err", err, 1);
      repeat (10) @(negedge CLK);
      chk("nk_err_hold", err, 1);

      // 0xFF clears err; a 5-cycle clock glitch must not advance the frame
      begin_xfer(8'hFF, "ff");
      repeat (15) @(negedge CLK);
      kb_c_low = 1'b1;
      repeat (5) @(negedge CLK);
      kb_c_low = 1'b0;
      repeat (20) @(negedge CLK);
      chk("ff_glitch_no_adv", ps2d_oe, 1);
      kb_send(11, 1'b0, rec, blow);
      chk("ff_bits", rec, 10'h000);
      wait_done(100, cyc);
      chk("ff_done", tx_done_tick, 1);
      chk("ff_err", err, 0);
      repeat (5) @(negedge CLK);

      // Device stops after 4 falls: watchdog aborts
      begin_xfer(8'h12, "to");
      kb_send(4, 1'b0, rec, blow);
      wait_done(TO + 100, cyc);
      chk("to_done", tx_done_tick, 1);
      chk("to_window", (cyc >= TO - 30) && (cyc <= TO), 1);
      chk("to_err", err, 1);
      chk("to_oe", {ps2c_oe, ps2d_oe}, 2'b00);
      chk("to_busy", busy, 0);
      repeat (5) @(negedge CLK);

      // Reset in the middle of SHIFT while data is driven low (d1 of 0xED = 0)
      begin_xfer(8'hED, "mr");
      kb_send(2, 1'b0, rec, blow);
      chk("mr_pre_doe", ps2d_oe, 1);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      chk("mr_c_oe", ps2c_oe, 0);
      chk("mr_d_oe", ps2d_oe, 0);
      chk("mr_busy", busy, 0);
      chk("mr_err", err, 0);
      @(negedge CLK);
      reset = 1'b0;
      repeat (60) @(negedge CLK);
      chk("mr_no_done", done_cnt - d0, 0);
      chk("mr_idle", {busy, ps2c_oe, ps2d_oe}, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
